// File: rtl/smart_downcounter.sv
// smart_downcounter: loadable down-counter with one-shot and periodic modes.
// A reload register captures data_in on load; start launches or restarts a
// countdown, pause freezes it. Each 1->0 step emits a one-cycle zero_pulse.
// In one-shot mode the counter then parks in DONE. In periodic mode it shows
// 0 for one cycle and then reloads, giving a period of reload+1 cycles.
//
// Control priority each cycle: load > start > pause > normal count.
// All outputs come straight from registers or are decoded from the state
// register. fsm_state exposes the raw state encoding for observation:
// IDLE=0, RUN=1, HOLD=2, DONE=3.
module smart_downcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             pause,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero_pulse,
    output logic             done,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_next;
    logic             pulse_next;

    // State, count, reload value and pulse registers; reset aborts everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= CNT_ZERO;
            reload_q   <= CNT_ZERO;
            zero_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_q   <= reload_next;
            zero_pulse <= pulse_next;
        end
    end

    // Next-state and next-count decode in priority order load > start > pause > count.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_q;
        pulse_next  = 1'b0;

        if (load) begin
            count_next  = data_in;
            reload_next = data_in;
            state_next  = IDLE;
        end else if (start) begin
            case (state)
                IDLE: begin
                    // An empty counter has nothing to count down.
                    if (count != CNT_ZERO) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    count_next = reload_q;
                    state_next = (reload_q != CNT_ZERO) ? RUN : IDLE;
                end
                default: begin
                    // RUN or HOLD: restart from the reload value.
                    count_next = reload_q;
                    state_next = RUN;
                end
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = HOLD;
                    end else if (count == CNT_ONE) begin
                        // Terminal step; reload_en only matters on this edge.
                        count_next = CNT_ZERO;
                        pulse_next = 1'b1;
                        if (!reload_en) begin
                            state_next = DONE;
                        end
                    end else if (count == CNT_ZERO) begin
                        // Periodic mode: the zero cycle is over, reload.
                        count_next = reload_q;
                    end else begin
                        count_next = count - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    // IDLE and DONE hold their count.
                end
            endcase
        end
    end

    // Status levels decoded from the state register.
    always_comb begin
        busy      = (state == RUN) || (state == HOLD);
        done      = (state == DONE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_smart_downcounter.sv
// Directed bench for smart_downcounter: a table of per-cycle vectors with
// hand-computed results, followed by hand-written sequences for the
// asynchronous-reset corner cases.
module tb_smart_downcounter;

    localparam int W = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] data_in;
    logic         start;
    logic         pause;
    logic         reload_en;
    logic [W-1:0] count;
    logic         busy;
    logic         zero_pulse;
    logic         done;
    logic [1:0]   fsm_state;

    int total;
    int bad;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] din;
        logic         st;
        logic         pa;
        logic         re;
        logic [W-1:0] e_cnt;
        logic         e_busy;
        logic         e_zp;
        logic         e_done;
        logic [1:0]   e_state;
    } vec_t;

    vec_t vecs[$];

    smart_downcounter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .start     (start),
        .pause     (pause),
        .reload_en (reload_en),
        .count     (count),
        .busy      (busy),
        .zero_pulse(zero_pulse),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // Clock generation: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [W-1:0] c, input logic b, input logic z,
                             input logic d, input logic [1:0] s);
        check("count", idx, 32'(count), 32'(c));
        check("busy", idx, 32'(busy), 32'(b));
        check("zero_pulse", idx, 32'(zero_pulse), 32'(z));
        check("done", idx, 32'(done), 32'(d));
        check("state", idx, 32'(fsm_state), 32'(s));
    endtask

    // rst, ld, din, st, pa, re  ->  count, busy, zero_pulse, done, state
    task automatic add(input logic rst, input logic ld, input logic [W-1:0] din, input logic st,
                       input logic pa, input logic re, input logic [W-1:0] c, input logic b,
                       input logic z, input logic d, input logic [1:0] s);
        vec_t v;
        v.rst = rst; v.ld = ld; v.din = din; v.st = st; v.pa = pa; v.re = re;
        v.e_cnt = c; v.e_busy = b; v.e_zp = z; v.e_done = d; v.e_state = s;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        load = 1'b0; start = 1'b0; pause = 1'b0; reload_en = 1'b0; data_in = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive_idle();

        // Reset with all inputs low.
        add(0,0,  0,0,0,0,   0,0,0,0,S_IDLE);
        add(1,0,  0,0,0,0,   0,0,0,0,S_IDLE);
        // One-shot: load 3, start -> 3,3,2,1,0 then DONE held.
        add(1,1,  3,0,0,0,   3,0,0,0,S_IDLE);
        add(1,0,  0,1,0,0,   3,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   2,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   1,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   0,0,1,1,S_DONE);
        add(1,0,  0,0,0,0,   0,0,0,1,S_DONE);
        add(1,0, 77,0,0,0,   0,0,0,1,S_DONE);   // data_in change without load
        add(1,0,  0,0,0,0,   0,0,0,1,S_DONE);
        add(1,0,  0,1,0,0,   3,1,0,0,S_RUN);    // start in DONE reloads 3
        // Periodic: load 2, start -> 2,2,1,0,2,1,0,2,1,0.
        add(1,1,  2,0,0,1,   2,0,0,0,S_IDLE);
        add(1,0,  0,1,0,1,   2,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   1,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   0,1,1,0,S_RUN);
        add(1,0,  0,0,0,1,   2,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   1,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   0,1,1,0,S_RUN);
        add(1,0,  0,0,0,1,   2,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   1,1,0,0,S_RUN);
        add(1,0,  0,0,0,1,   0,1,1,0,S_RUN);
        // reload_en matters only on the 1->0 edge.
        add(1,0,  0,0,0,0,   2,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   1,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   0,0,1,1,S_DONE);
        // Pause: load 10, start, 3 decrements, pause 4 cycles, resume.
        add(1,1, 10,0,0,0,  10,0,0,0,S_IDLE);
        add(1,0,  0,1,0,0,  10,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   9,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   8,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   7,1,0,0,S_RUN);
        add(1,0,  0,0,1,0,   7,1,0,0,S_HOLD);
        add(1,0,  0,0,1,0,   7,1,0,0,S_HOLD);
        add(1,0,  0,0,1,0,   7,1,0,0,S_HOLD);
        add(1,0,  0,0,1,0,   7,1,0,0,S_HOLD);
        add(1,0,  0,0,0,0,   7,1,0,0,S_RUN);    // resume edge holds count
        add(1,0,  0,0,0,0,   6,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   5,1,0,0,S_RUN);
        // Restart in RUN reloads 10.
        add(1,0,  0,1,0,0,  10,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   9,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   8,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   7,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   6,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   5,1,0,0,S_RUN);
        // load + start + pause together at count 5: load wins.
        add(1,1,200,1,1,0, 200,0,0,0,S_IDLE);
        // Restart from HOLD.
        add(1,0,  0,1,0,0, 200,1,0,0,S_RUN);
        add(1,0,  0,0,0,0, 199,1,0,0,S_RUN);
        add(1,0,  0,0,1,0, 199,1,0,0,S_HOLD);
        add(1,0,  0,1,1,0, 200,1,0,0,S_RUN);
        add(1,0,  0,0,0,0, 199,1,0,0,S_RUN);
        // load 0 then start: ignored.
        add(1,1,  0,0,0,0,   0,0,0,0,S_IDLE);
        add(1,0,  0,1,0,0,   0,0,0,0,S_IDLE);
        add(1,0,  0,1,0,0,   0,0,0,0,S_IDLE);
        // Countdown from 6 to 4 for the async reset sequence.
        add(1,1,  6,0,0,0,   6,0,0,0,S_IDLE);
        add(1,0,  0,1,0,0,   6,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   5,1,0,0,S_RUN);
        add(1,0,  0,0,0,0,   4,1,0,0,S_RUN);

        // Apply each vector just after a rising edge, check just after the next.
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            load      = vecs[i].ld;
            data_in   = vecs[i].din;
            start     = vecs[i].st;
            pause     = vecs[i].pa;
            reload_en = vecs[i].re;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_zp, vecs[i].e_done, vecs[i].e_state);
        end

        // Asynchronous reset between edges at count=4: clears without a clock.
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        check_all(1000, 0, 0, 0, 0, S_IDLE);
        // Held through an edge: still cleared, no zero_pulse.
        @(posedge clk);
        #1;
        check_all(1001, 0, 0, 0, 0, S_IDLE);
        // Release; start with an empty counter is ignored.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all(1002, 0, 0, 0, 0, S_IDLE);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_all(1003, 0, 0, 0, 0, S_IDLE);
        start = 1'b0;

        // Async reset in periodic mode right before the terminal edge.
        load = 1'b1; data_in = 8'd2; reload_en = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_all(1004, 1, 1, 0, 0, S_RUN);
        #3;
        reset = 1'b0;
        #1;
        check_all(1005, 0, 0, 0, 0, S_IDLE);
        @(posedge clk);
        #1;
        check_all(1006, 0, 0, 0, 0, S_IDLE);
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        check_all(1007, 0, 0, 0, 0, S_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
